// File: rtl/dcache_req_scheduler.sv
// Round-robin arbiter in front of the HPDcache request port: TID allocation, response routing, fence drain.
// Optional DCACHE_REQ_SCHED_PTW_PRIO_EN: requester 0 (PTW) wins whenever eligible.
module dcache_req_scheduler #(
  parameter int NR_REQ          = 4,
  parameter int REQ_W           = 128,
  parameter int DCACHE_ID_WIDTH = 3,
  parameter int MAX_OUTSTANDING = 7
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [NR_REQ-1:0]           req_valid_i,
  output logic [NR_REQ-1:0]           req_ready_o,
  input  logic [NR_REQ*REQ_W-1:0]     req_payload_i,
  input  logic [NR_REQ-1:0]           req_need_rsp_i,
  output logic                        cache_req_valid_o,
  input  logic                        cache_req_ready_i,
  output logic [REQ_W-1:0]            cache_req_payload_o,
  output logic [DCACHE_ID_WIDTH-1:0]  cache_req_tid_o,
  output logic                        cache_req_need_rsp_o,
  input  logic                        cache_rsp_valid_i,
  input  logic [DCACHE_ID_WIDTH-1:0]  cache_rsp_tid_i,
  output logic [NR_REQ-1:0]           rsp_valid_o,
  input  logic                        flush_i,
  output logic                        flush_done_o,
  output logic [DCACHE_ID_WIDTH:0]    outstanding_o,
  output logic                        err_o
);

  localparam int NTID = 2**DCACHE_ID_WIDTH;
  localparam int IW   = (NR_REQ > 1) ? $clog2(NR_REQ) : 1;
  localparam int CW   = DCACHE_ID_WIDTH + 1;
  localparam int TW   = DCACHE_ID_WIDTH;

  typedef enum logic [1:0] {
    S_IDLE, S_DRAIN, S_DONE, S_WAIT
  } state_e;

  state_e            state_q, state_d;
  logic              slot_vld_q, slot_vld_d;
  logic [REQ_W-1:0]  slot_pl_q, slot_pl_d;
  logic [TW-1:0]     slot_tid_q, slot_tid_d;
  logic              slot_nr_q, slot_nr_d;
  logic [NTID-1:0]   busy_q, busy_d;
  logic [IW-1:0]     owner_q [NTID];
  logic [IW-1:0]     owner_d [NTID];
  logic [IW-1:0]     ptr_q, ptr_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              err_q, err_d;

  logic              tid_free;
  logic [TW-1:0]     free_tid;
  logic              cap_ok;
  logic [NR_REQ-1:0] elig, rr_elig;
  logic              gnt_vld, ptw_gnt;
  logic [IW-1:0]     gnt_idx, cand;
  logic              can_load, fire, alloc, rsp_hit;

  always_comb begin
    tid_free = 1'b0;
    free_tid = '0;
    for (int t = NTID-1; t >= 0; t--) begin
      if (!busy_q[t]) begin
        tid_free = 1'b1;
        free_tid = TW'(t);
      end
    end
  end

  // Frees take effect next cycle: eligibility looks only at busy_q.
  assign cap_ok = tid_free && (cnt_q < CW'(MAX_OUTSTANDING));

  always_comb begin
    for (int i = 0; i < NR_REQ; i++) begin
      elig[i] = req_valid_i[i] && (!req_need_rsp_i[i] || cap_ok);
    end
  end

`ifdef DCACHE_REQ_SCHED_PTW_PRIO_EN
  assign rr_elig = elig & ~NR_REQ'(1);
`else
  assign rr_elig = elig;
`endif

  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    ptw_gnt = 1'b0;
    cand    = '0;
    for (int k = 0; k < NR_REQ; k++) begin
      cand = IW'((int'(ptr_q) + k) % NR_REQ);
      if (!gnt_vld && rr_elig[cand]) begin
        gnt_vld = 1'b1;
        gnt_idx = cand;
      end
    end
`ifdef DCACHE_REQ_SCHED_PTW_PRIO_EN
    if (elig[0]) begin
      gnt_vld = 1'b1;
      gnt_idx = '0;
      ptw_gnt = 1'b1;
    end
`endif
  end

  assign can_load = !slot_vld_q || cache_req_ready_i;
  assign fire     = gnt_vld && can_load && (state_q != S_DRAIN) && !rst_i;
  assign alloc    = fire && req_need_rsp_i[gnt_idx];
  assign rsp_hit  = cache_rsp_valid_i && busy_q[cache_rsp_tid_i];

  always_comb begin
    for (int i = 0; i < NR_REQ; i++) begin
      req_ready_o[i] = fire && (gnt_idx == IW'(i));
      rsp_valid_o[i] = rsp_hit && !rst_i &&
                       (owner_q[cache_rsp_tid_i] == IW'(i));
    end
  end

  always_comb begin
    busy_d  = busy_q;
    owner_d = owner_q;
    err_d   = err_q;
    ptr_d   = ptr_q;
    if (rsp_hit) begin
      busy_d[cache_rsp_tid_i] = 1'b0;
    end else if (cache_rsp_valid_i) begin
      err_d = 1'b1;
    end
    if (alloc) begin
      busy_d[free_tid]  = 1'b1;
      owner_d[free_tid] = gnt_idx;
    end
    cnt_d = cnt_q + CW'(alloc) - CW'(rsp_hit);
    if (fire && !ptw_gnt) begin
      ptr_d = IW'((int'(gnt_idx) + 1) % NR_REQ);
    end
  end

  always_comb begin
    slot_vld_d = slot_vld_q;
    slot_pl_d  = slot_pl_q;
    slot_tid_d = slot_tid_q;
    slot_nr_d  = slot_nr_q;
    if (can_load) begin
      slot_vld_d = fire;
    end
    if (fire) begin
      slot_pl_d  = req_payload_i[int'(gnt_idx)*REQ_W +: REQ_W];
      slot_nr_d  = req_need_rsp_i[gnt_idx];
      slot_tid_d = req_need_rsp_i[gnt_idx] ? free_tid : '0;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (flush_i) state_d = S_DRAIN;
      S_DRAIN: if (cnt_d == '0 && !slot_vld_d) state_d = S_DONE;
      S_DONE:  state_d = S_WAIT;
      S_WAIT:  if (!flush_i) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      slot_vld_q <= 1'b0;
      slot_pl_q  <= '0;
      slot_tid_q <= '0;
      slot_nr_q  <= 1'b0;
      busy_q     <= '0;
      ptr_q      <= '0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
      for (int t = 0; t < NTID; t++) owner_q[t] <= '0;
    end else begin
      state_q    <= state_d;
      slot_vld_q <= slot_vld_d;
      slot_pl_q  <= slot_pl_d;
      slot_tid_q <= slot_tid_d;
      slot_nr_q  <= slot_nr_d;
      busy_q     <= busy_d;
      ptr_q      <= ptr_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
      for (int t = 0; t < NTID; t++) owner_q[t] <= owner_d[t];
    end
  end

  assign cache_req_valid_o    = slot_vld_q;
  assign cache_req_payload_o  = slot_pl_q;
  assign cache_req_tid_o      = slot_tid_q;
  assign cache_req_need_rsp_o = slot_nr_q;
  assign flush_done_o         = (state_q == S_DONE);
  assign outstanding_o        = cnt_q;
  assign err_o                = err_q;

endmodule

// File: tb/tb_dcache_req_scheduler.sv
// Scoreboard bench for dcache_req_scheduler: directed vectors, queue-based request checker.
// Honours DCACHE_REQ_SCHED_PTW_PRIO_EN for the arbitration-priority vectors.
module tb_dcache_req_scheduler;
  localparam int NR  = 4;
  localparam int W   = 128;
  localparam int IDW = 3;

  logic              clk = 1'b0;
  logic              rst_i;
  logic [NR-1:0]     req_valid_i, req_ready_o, req_need_rsp_i, rsp_valid_o;
  logic [NR*W-1:0]   req_payload_i;
  logic              cache_req_valid_o, cache_req_ready_i, cache_req_need_rsp_o;
  logic [W-1:0]      cache_req_payload_o;
  logic [IDW-1:0]    cache_req_tid_o, cache_rsp_tid_i;
  logic              cache_rsp_valid_i, flush_i, flush_done_o, err_o;
  logic [IDW:0]      outstanding_o;

  always #5 clk = ~clk;

  dcache_req_scheduler dut (
    .clk_i(clk), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_payload_i(req_payload_i), .req_need_rsp_i(req_need_rsp_i),
    .cache_req_valid_o(cache_req_valid_o), .cache_req_ready_i(cache_req_ready_i),
    .cache_req_payload_o(cache_req_payload_o), .cache_req_tid_o(cache_req_tid_o),
    .cache_req_need_rsp_o(cache_req_need_rsp_o),
    .cache_rsp_valid_i(cache_rsp_valid_i), .cache_rsp_tid_i(cache_rsp_tid_i),
    .rsp_valid_o(rsp_valid_o), .flush_i(flush_i), .flush_done_o(flush_done_o),
    .outstanding_o(outstanding_o), .err_o(err_o)
  );

  typedef struct {
    logic [W-1:0]   pl;
    logic [IDW-1:0] tid;
    logic           nr;
  } exp_t;

  exp_t expq[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic logic [W-1:0] pl(input int r, input int tag);
    return {8'hA5, 112'h0, 8'(tag*16 + r)};
  endfunction

  function automatic exp_t mk(input int r, input int tag, input int tid, input bit nr);
    exp_t e;
    e.pl  = pl(r, tag);
    e.tid = IDW'(tid);
    e.nr  = nr;
    return e;
  endfunction

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic samp();
    @(negedge clk);
  endtask

  task automatic set_pl(input int r, input int tag);
    req_payload_i[r*W +: W] = pl(r, tag);
  endtask

  // Request-side monitor: every accepted cache request must match the queue head.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_i && cache_req_valid_o && cache_req_ready_i) begin
        n_tests++;
        if (expq.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_req: got pl %0h tid %0d, none expected",
                   cache_req_payload_o, cache_req_tid_o);
        end else begin
          e = expq.pop_front();
          if (cache_req_payload_o !== e.pl || cache_req_tid_o !== e.tid ||
              cache_req_need_rsp_o !== e.nr) begin
            n_fail++;
            $display("FAIL cache_req: got pl %0h tid %0d nr %0b expected pl %0h tid %0d nr %0b",
                     cache_req_payload_o, cache_req_tid_o, cache_req_need_rsp_o,
                     e.pl, e.tid, e.nr);
          end
        end
      end
    end
  end

  int rr_ord[5] = '{0, 1, 2, 3, 0};
`ifdef DCACHE_REQ_SCHED_PTW_PRIO_EN
  int pr_ord[4] = '{0, 0, 0, 0};
`else
  int pr_ord[4] = '{2, 0, 2, 0};
`endif

  initial begin
    rst_i = 1'b1;
    req_valid_i = '0;
    req_need_rsp_i = '0;
    req_payload_i = '0;
    cache_req_ready_i = 1'b0;
    cache_rsp_valid_i = 1'b0;
    cache_rsp_tid_i = '0;
    flush_i = 1'b0;

    repeat (3) tick();
    samp();
    chk("rst_cache_valid", W'(cache_req_valid_o), W'(0));
    chk("rst_ready", W'(req_ready_o), W'(0));
    chk("rst_flush_done", W'(flush_done_o), W'(0));
    chk("rst_err", W'(err_o), W'(0));
    chk("rst_outstanding", W'(outstanding_o), W'(0));
    tick();
    rst_i = 1'b0;

    // Round-robin, no responses needed
    for (int r = 0; r < NR; r++) set_pl(r, 0);
    cache_req_ready_i = 1'b1;
    for (int k = 0; k < 5; k++) expq.push_back(mk(rr_ord[k], 0, 0, 1'b0));
    req_valid_i = 4'hF;
    for (int k = 0; k < 5; k++) begin
      samp();
      chk("rr_ready", W'(req_ready_o), W'(4'b0001 << rr_ord[k]));
      if (k > 0) chk("rr_valid", W'(cache_req_valid_o), W'(1));
      tick();
    end
    req_valid_i = '0;
    samp();
    chk("rr_valid_tail", W'(cache_req_valid_o), W'(1));
    tick();

    // Backpressure with a full slot
    cache_req_ready_i = 1'b0;
    set_pl(3, 1);
    set_pl(1, 1);
    expq.push_back(mk(3, 1, 0, 1'b0));
    expq.push_back(mk(1, 1, 0, 1'b0));
    req_valid_i = 4'b1000;
    samp();
    chk("bp_first_ready", W'(req_ready_o), W'(4'b1000));
    tick();
    req_valid_i = 4'b0010;
    set_pl(3, 2);
    repeat (5) begin
      samp();
      chk("bp_ready_zero", W'(req_ready_o), W'(0));
      chk("bp_payload", cache_req_payload_o, pl(3, 1));
      chk("bp_valid", W'(cache_req_valid_o), W'(1));
      tick();
    end
    cache_req_ready_i = 1'b1;
    samp();
    chk("bp_release_ready", W'(req_ready_o), W'(4'b0010));
    tick();
    req_valid_i = '0;
    samp();
    tick();

    // TID exhaustion on requester 1
    set_pl(1, 2);
    req_need_rsp_i = 4'b0010;
    for (int k = 0; k < 7; k++) expq.push_back(mk(1, 2, k, 1'b1));
    req_valid_i = 4'b0010;
    for (int k = 0; k < 7; k++) begin
      samp();
      chk("tid_ready", W'(req_ready_o), W'(4'b0010));
      tick();
    end
    samp();
    chk("tid_stall_ready", W'(req_ready_o), W'(0));
    chk("tid_outstanding7", W'(outstanding_o), W'(7));
    tick();
    cache_rsp_valid_i = 1'b1;
    cache_rsp_tid_i = 3'd3;
    samp();
    chk("tid3_route", W'(rsp_valid_o), W'(4'b0010));
    chk("tid3_not_reused_now", W'(req_ready_o), W'(0));
    tick();
    cache_rsp_valid_i = 1'b0;
    expq.push_back(mk(1, 2, 3, 1'b1));
    samp();
    chk("tid3_regrant_ready", W'(req_ready_o), W'(4'b0010));
    chk("tid_outstanding6", W'(outstanding_o), W'(6));
    tick();
    req_valid_i = '0;
    samp();
    chk("tid_outstanding7b", W'(outstanding_o), W'(7));
    chk("tid3_slot_tid", W'(cache_req_tid_o), W'(3));
    tick();
    for (int k = 0; k < 7; k++) begin
      cache_rsp_valid_i = 1'b1;
      cache_rsp_tid_i = IDW'(k);
      samp();
      chk("tid_free_route", W'(rsp_valid_o), W'(4'b0010));
      tick();
    end
    cache_rsp_valid_i = 1'b0;
    samp();
    chk("tid_outstanding0", W'(outstanding_o), W'(0));
    chk("tid_err0", W'(err_o), W'(0));
    tick();

    // Routing and stale-TID error
    req_need_rsp_i = 4'b0100;
    set_pl(2, 3);
    expq.push_back(mk(2, 3, 0, 1'b1));
    req_valid_i = 4'b0100;
    samp();
    chk("route_ready", W'(req_ready_o), W'(4'b0100));
    tick();
    req_valid_i = '0;
    samp();
    tick();
    cache_rsp_valid_i = 1'b1;
    cache_rsp_tid_i = '0;
    samp();
    chk("route_rsp", W'(rsp_valid_o), W'(4'b0100));
    chk("route_err0", W'(err_o), W'(0));
    tick();
    samp();
    chk("stale_rsp", W'(rsp_valid_o), W'(0));
    tick();
    cache_rsp_valid_i = 1'b0;
    samp();
    chk("stale_err", W'(err_o), W'(1));
    chk("stale_outstanding", W'(outstanding_o), W'(0));
    tick();
    samp();
    chk("stale_err_sticky", W'(err_o), W'(1));
    tick();

    // Fence with 3 outstanding
    req_need_rsp_i = 4'b0001;
    set_pl(0, 4);
    for (int k = 0; k < 3; k++) expq.push_back(mk(0, 4, k, 1'b1));
    req_valid_i = 4'b0001;
    repeat (3) begin
      samp();
      chk("fence_fill_ready", W'(req_ready_o), W'(4'b0001));
      tick();
    end
    req_valid_i = '0;
    samp();
    chk("fence_outstanding3", W'(outstanding_o), W'(3));
    tick();
    flush_i = 1'b1;
    samp();
    chk("fence_done_c0", W'(flush_done_o), W'(0));
    tick();
    req_need_rsp_i = '0;
    set_pl(3, 5);
    req_valid_i = 4'b1000;
    repeat (3) begin
      samp();
      chk("fence_no_grant", W'(req_ready_o), W'(0));
      chk("fence_done_early", W'(flush_done_o), W'(0));
      tick();
    end
    req_valid_i = '0;
    for (int k = 0; k < 3; k++) begin
      cache_rsp_valid_i = 1'b1;
      cache_rsp_tid_i = IDW'(k);
      samp();
      chk("fence_rsp_route", W'(rsp_valid_o), W'(4'b0001));
      chk("fence_done_wait", W'(flush_done_o), W'(0));
      tick();
    end
    cache_rsp_valid_i = 1'b0;
    samp();
    chk("fence_done_pulse", W'(flush_done_o), W'(1));
    tick();
    samp();
    chk("fence_done_one", W'(flush_done_o), W'(0));
    tick();
    flush_i = 1'b0;
    tick();
    tick();

    // Fence with nothing outstanding
    flush_i = 1'b1;
    samp();
    chk("fence0_c0", W'(flush_done_o), W'(0));
    tick();
    samp();
    chk("fence0_c1", W'(flush_done_o), W'(0));
    tick();
    samp();
    chk("fence0_c2", W'(flush_done_o), W'(1));
    tick();
    samp();
    chk("fence0_c3", W'(flush_done_o), W'(0));
    tick();
    flush_i = 1'b0;
    tick();
    tick();

    // PTW vs requester 2
    set_pl(0, 6);
    set_pl(2, 6);
    for (int k = 0; k < 4; k++) expq.push_back(mk(pr_ord[k], 6, 0, 1'b0));
    req_valid_i = 4'b0101;
    for (int k = 0; k < 4; k++) begin
      samp();
      chk("prio_ready", W'(req_ready_o), W'(4'b0001 << pr_ord[k]));
      tick();
    end
    req_valid_i = '0;
    samp();
    tick();

    // Reset in the middle of traffic
    req_need_rsp_i = 4'b0010;
    set_pl(1, 7);
    expq.push_back(mk(1, 7, 0, 1'b1));
    req_valid_i = 4'b0010;
    samp();
    tick();
    req_valid_i = '0;
    samp();
    chk("mid_outstanding1", W'(outstanding_o), W'(1));
    tick();
    cache_req_ready_i = 1'b0;
    set_pl(1, 8);
    req_valid_i = 4'b0010;
    tick();
    req_valid_i = '0;
    samp();
    chk("mid_slot_held", W'(cache_req_valid_o), W'(1));
    tick();
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    cache_req_ready_i = 1'b1;
    samp();
    chk("mid_rst_valid", W'(cache_req_valid_o), W'(0));
    chk("mid_rst_outstanding", W'(outstanding_o), W'(0));
    chk("mid_rst_err", W'(err_o), W'(0));
    tick();
    cache_rsp_valid_i = 1'b1;
    cache_rsp_tid_i = '0;
    samp();
    chk("mid_rsp_dropped", W'(rsp_valid_o), W'(0));
    tick();
    cache_rsp_valid_i = 1'b0;
    samp();
    chk("mid_rsp_err", W'(err_o), W'(1));
    tick();

    repeat (2) tick();
    chk("queue_drained", W'(expq.size()), W'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
